// File: rtl/sclk_gen_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sclk_gen_ctrl
// Description : Run-time controller for the slow-clock divider. Produces a
//               50% duty sclk and a one-cycle tick on each sclk rise. Runs
//               either continuously or for a fixed number of full periods.
//               A new divisor arrives over a valid/ready handshake and is
//               applied only on a full-period boundary (the falling edge of
//               sclk) or while idle, so sclk never emits a short phase.
// Revision    : 1.0 - initial release
// ============================================================================
module sclk_gen_ctrl #(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 24414,
  parameter int BURST_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CNT_W-1:0]   cfg_div,
  input  logic               start,
  input  logic               mode,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               stop,
  output logic               sclk,
  output logic               tick,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    BURST     = 2'd2,
    STOP_PEND = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0]   C_CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [BURST_W-1:0] C_BURST_ONE = {{(BURST_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]   C_DIV_RST   = CNT_W'(DEFAULT_DIV);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   div_q, div_d;
  logic               pend_q, pend_d;
  logic [CNT_W-1:0]   pend_div_q, pend_div_d;
  logic [BURST_W-1:0] rem_q, rem_d;
  logic               sclk_q, sclk_d;
  logic               tick_q, tick_d;
  logic               done_q, done_d;
  logic               busy_q, busy_d;
  logic               cfg_ready_q, cfg_ready_d;

  logic               w_half_end;
  logic               w_fpb;
  logic               w_accept;
  logic               w_apply;

  // Next-state logic: divisor handshake, half-period counting and run sequencing
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    pend_d     = pend_q;
    pend_div_d = pend_div_q;
    rem_d      = rem_q;
    sclk_d     = sclk_q;
    tick_d     = 1'b0;
    done_d     = 1'b0;

    w_half_end = (cnt_q == div_q);
    // Full-period boundary: the half period that ends here is the high one
    w_fpb      = (state_q != IDLE) && w_half_end && sclk_q;
    w_accept   = cfg_valid && cfg_ready_q;
    // A value accepted on this edge is not yet in pend_q, so an FPB on the
    // acceptance edge naturally leaves it for the following boundary
    w_apply    = pend_q && ((state_q == IDLE) || w_fpb);

    if (w_apply) begin
      div_d  = pend_div_q;
      pend_d = 1'b0;
    end
    if (w_accept) begin
      pend_d     = 1'b1;
      pend_div_d = cfg_div;
    end

    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        sclk_d = 1'b0;
        if (start) begin
          if (!mode) begin
            state_d = RUN;
          end else if (burst_len != '0) begin
            state_d = BURST;
            rem_d   = burst_len;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      default: begin
        if (stop && (state_q != STOP_PEND) && !sclk_q) begin
          // Low phase: abandon it at once so no partial high phase appears
          state_d = IDLE;
          cnt_d   = '0;
          sclk_d  = 1'b0;
          done_d  = 1'b1;
        end else if (w_half_end) begin
          cnt_d  = '0;
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            tick_d = 1'b1;
          end else begin
            if (state_q == BURST) begin
              rem_d = rem_q - C_BURST_ONE;
            end
            if ((state_q == STOP_PEND) || stop ||
                ((state_q == BURST) && (rem_q == C_BURST_ONE))) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + C_CNT_ONE;
          // Only reachable in the high phase: finish it, then stop at the fall
          if (stop && (state_q != STOP_PEND)) begin
            state_d = STOP_PEND;
          end
        end
      end
    endcase

    busy_d      = (state_d != IDLE);
    cfg_ready_d = ~pend_d;
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      div_q       <= C_DIV_RST;
      pend_q      <= 1'b0;
      pend_div_q  <= '0;
      rem_q       <= '0;
      sclk_q      <= 1'b0;
      tick_q      <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      cfg_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      pend_q      <= pend_d;
      pend_div_q  <= pend_div_d;
      rem_q       <= rem_d;
      sclk_q      <= sclk_d;
      tick_q      <= tick_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      cfg_ready_q <= cfg_ready_d;
    end
  end

  assign sclk      = sclk_q;
  assign tick      = tick_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cfg_ready = cfg_ready_q;

endmodule
`default_nettype wire

// File: tb/tb_sclk_gen_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sclk_gen_ctrl
// Description : Self-checking bench for sclk_gen_ctrl. A behavioural model
//               tracks the run as "cycles left in this half period", the
//               output level and the periods left, and every cycle the DUT
//               outputs are compared against it. Directed steps exercise the
//               timing cases, then randomized traffic follows.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sclk_gen_ctrl;

  localparam int CNT_W   = 16;
  localparam int BURST_W = 8;
  localparam int DEF_DIV = 3;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               cfg_valid = 1'b0;
  logic [CNT_W-1:0]   cfg_div = '0;
  logic               start = 1'b0;
  logic               mode = 1'b0;
  logic [BURST_W-1:0] burst_len = '0;
  logic               stop = 1'b0;
  logic               cfg_ready, sclk, tick, busy, done;

  sclk_gen_ctrl #(
    .CNT_W      (CNT_W),
    .DEFAULT_DIV(DEF_DIV),
    .BURST_W    (BURST_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_div  (cfg_div),
    .start    (start),
    .mode     (mode),
    .burst_len(burst_len),
    .stop     (stop),
    .sclk     (sclk),
    .tick     (tick),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit m_active, m_stopping, m_burst, m_level, m_tick, m_done, m_pend;
  int m_left, m_periods, m_div, m_pdiv;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_active = 0; m_stopping = 0; m_burst = 0; m_level = 0;
    m_tick = 0; m_done = 0; m_pend = 0;
    m_left = 0; m_periods = 0; m_div = DEF_DIV; m_pdiv = 0;
  endfunction

  // Advance the model by one clock using the inputs presented for this edge
  function automatic void model_step();
    bit acc;
    m_tick = 0;
    m_done = 0;
    acc = cfg_valid && !m_pend;
    if (!m_active) begin
      if (m_pend) begin m_div = m_pdiv; m_pend = 0; end
      if (start) begin
        m_level = 0;
        m_stopping = 0;
        if (!mode) begin
          m_active = 1; m_burst = 0; m_left = m_div + 1;
        end else if (burst_len != 0) begin
          m_active = 1; m_burst = 1; m_periods = burst_len; m_left = m_div + 1;
        end else begin
          m_done = 1;
        end
      end
    end else if (stop && !m_stopping && !m_level) begin
      m_active = 0; m_done = 1;
    end else if (m_left == 1) begin
      if (!m_level) begin
        m_level = 1; m_tick = 1; m_left = m_div + 1;
      end else begin
        m_level = 0;
        if (m_pend) begin m_div = m_pdiv; m_pend = 0; end
        if (m_burst) m_periods--;
        if (m_stopping || stop || (m_burst && m_periods == 0)) begin
          m_active = 0; m_done = 1;
        end else begin
          m_left = m_div + 1;
        end
      end
    end else begin
      m_left--;
      if (stop && m_level) m_stopping = 1;
    end
    if (acc) begin m_pend = 1; m_pdiv = int'(cfg_div); end
  endfunction

  task automatic compare_all();
    check("sclk", sclk, m_level);
    check("tick", tick, m_tick);
    check("busy", busy, m_active);
    check("done", done, m_done);
    check("cfg_ready", cfg_ready, !m_pend);
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic wait_tick(input int max, output int n);
    n = 0;
    do begin cycle(); n++; end while (!tick && n < max);
  endtask

  task automatic wait_done(input int max, output int n);
    n = 0;
    do begin cycle(); n++; end while (!done && n < max);
  endtask

  initial begin
    int n;
    int ticks;

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    compare_all();
    rst_n = 1'b1;

    // Continuous run at the reset divisor
    start = 1'b1; mode = 1'b0;
    cycle();
    start = 1'b0;
    check("t1_busy", busy, 1);
    wait_tick(20, n);
    check("t1_first_tick", n, DEF_DIV + 1);
    wait_tick(20, n);
    check("t1_period", n, 2 * (DEF_DIV + 1));

    // Divisor offered in the high phase waits for the falling edge
    cfg_valid = 1'b1; cfg_div = 16'd1;
    cycle();
    cfg_valid = 1'b0;
    check("t3_ready_low", cfg_ready, 0);
    wait_tick(20, n);
    check("t3_to_tick", n, 5);
    check("t3_ready_back", cfg_ready, 1);
    wait_tick(20, n);
    check("t3_new_period", n, 4);

    // Back to divisor 3, then stop during the high phase
    cfg_valid = 1'b1; cfg_div = 16'd3;
    cycle();
    cfg_valid = 1'b0;
    wait_tick(20, n);
    check("t4_restore", n, 5);
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    check("t4_pend_busy", busy, 1);
    wait_done(20, n);
    check("t4_done_lat", n, 3);
    check("t4_idle", busy, 0);
    check("t4_sclk_low", sclk, 0);

    // Stop during the low phase ends at once
    start = 1'b1; mode = 1'b0;
    cycle();
    start = 1'b0;
    cycle();
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    check("t4b_done", done, 1);
    check("t4b_busy", busy, 0);
    check("t4b_sclk", sclk, 0);
    repeat (5) cycle();

    // Three-period burst
    start = 1'b1; mode = 1'b1; burst_len = 8'd3;
    cycle();
    start = 1'b0;
    ticks = 0;
    n = 0;
    do begin cycle(); n++; if (tick) ticks++; end while (!done && n < 100);
    check("t2_ticks", ticks, 3);
    check("t2_length", n, 24);
    check("t2_busy", busy, 0);
    check("t2_sclk", sclk, 0);

    // Zero-length burst
    start = 1'b1; mode = 1'b1; burst_len = 8'd0;
    cycle();
    start = 1'b0;
    check("t5_done", done, 1);
    check("t5_busy", busy, 0);
    check("t5_tick", tick, 0);
    cycle();
    check("t5_done_pulse", done, 0);

    // Stop on the final FPB of a burst, with a divisor pending
    start = 1'b1; mode = 1'b1; burst_len = 8'd1;
    cycle();
    start = 1'b0;
    cfg_valid = 1'b1; cfg_div = 16'd0;
    cycle();
    cfg_valid = 1'b0;
    repeat (6) cycle();
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    check("fin_done", done, 1);
    check("fin_busy", busy, 0);
    check("fin_ready", cfg_ready, 1);
    cycle();
    check("fin_single_done", done, 0);
    start = 1'b1; mode = 1'b0;
    cycle();
    start = 1'b0;
    wait_tick(20, n);
    check("div0_first", n, 1);
    wait_tick(20, n);
    check("div0_period", n, 2);
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    check("div0_stop_busy", busy, 0);

    // Asynchronous reset mid-burst with a divisor pending
    start = 1'b1; mode = 1'b1; burst_len = 8'd10;
    cycle();
    start = 1'b0;
    repeat (5) cycle();
    cfg_valid = 1'b1; cfg_div = 16'd7;
    cycle();
    cfg_valid = 1'b0;
    check("t6_ready_low", cfg_ready, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_sclk", sclk, 0);
    check("t6_busy", busy, 0);
    check("t6_tick", tick, 0);
    check("t6_done", done, 0);
    check("t6_ready", cfg_ready, 1);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    start = 1'b1; mode = 1'b0;
    cycle();
    start = 1'b0;
    wait_tick(20, n);
    check("t6_default_div", n, DEF_DIV + 1);

    // start and stop together in IDLE: start wins
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    wait_done(20, n);
    start = 1'b1; stop = 1'b1; mode = 1'b0;
    cycle();
    start = 1'b0; stop = 1'b0;
    check("both_busy", busy, 1);
    cycle();
    stop = 1'b1;
    cycle();
    stop = 1'b0;

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      start     = ($urandom_range(0, 19) == 0);
      mode      = 1'($urandom_range(0, 1));
      burst_len = 8'($urandom_range(0, 4));
      stop      = ($urandom_range(0, 39) == 0);
      cfg_valid = ($urandom_range(0, 7) == 0);
      cfg_div   = 16'($urandom_range(0, 4));
      cycle();
    end
    start = 1'b0; stop = 1'b0; cfg_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
